serial_logic_unit: RTL and testbench

SERIAL_LOGIC_UNIT -- requirements
Module: serial_logic_unit

---
 rtl/serial_logic_unit_pkg.sv | 21 ++
 rtl/serial_logic_unit_if.sv | 31 +++
 rtl/serial_logic_unit_logic_slice.sv | 26 ++
 rtl/serial_logic_unit.sv | 125 ++++++++++++
 tb/tb_serial_logic_unit.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/serial_logic_unit_pkg.sv
// rtl/serial_logic_unit_pkg.sv - opcodes, FSM states and helpers shared by the serial logic unit and its bench
package serial_logic_unit_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Opcodes 5..7 have no operation behind them and are reported through op_err.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/serial_logic_unit_if.sv
// rtl/serial_logic_unit_if.sv - command/response bundle of the serial logic unit
interface serial_logic_unit_if #(
  parameter int WIDTH = 32
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             overflow;
  logic             zero;
  logic             op_err;

  // Requester side: issues commands, consumes responses.
  modport master (
    output cmd_valid, cmd_op, a, b, rsp_ready,
    input  cmd_ready, rsp_valid, result, carryout, overflow, zero, op_err
  );

  // Unit side: accepts commands, produces responses.
  modport slave (
    input  cmd_valid, cmd_op, a, b, rsp_ready,
    output cmd_ready, rsp_valid, result, carryout, overflow, zero, op_err
  );

endinterface

// File: rtl/serial_logic_unit_logic_slice.sv
// rtl/serial_logic_unit_logic_slice.sv - combinational SLICE-wide bitwise operator
module logic_slice
  import serial_logic_unit_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [2:0]       op,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] y
);

  // Select the bitwise function; illegal opcodes yield zero.
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_NAND: y = ~(a & b);
      OP_OR:   y = a | b;
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/serial_logic_unit.sv
// rtl/serial_logic_unit.sv - bit-serial (slice-per-cycle) bitwise logic unit with valid/ready handshakes
module serial_logic_unit
  import serial_logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  serial_logic_unit_if.slave bus
);

  localparam int N_SLICES = WIDTH / SLICE;
  localparam int CNT_W    = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N_SLICES - 1);

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               err_q, err_d;

  logic [SLICE-1:0]   slice_a;
  logic [SLICE-1:0]   slice_b;
  logic [SLICE-1:0]   slice_y;

  // The single operator is fed the slice selected by the counter every RUN cycle.
  assign slice_a = a_q[int'(cnt_q)*SLICE +: SLICE];
  assign slice_b = b_q[int'(cnt_q)*SLICE +: SLICE];

  logic_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .op (op_q),
    .a  (slice_a),
    .b  (slice_b),
    .y  (slice_y)
  );

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d     = bus.cmd_op;
          a_d      = bus.a;
          b_d      = bus.b;
          cnt_d    = '0;
          result_d = '0;
          if (is_legal_op(bus.cmd_op)) begin
            state_d = ST_RUN;
            zero_d  = 1'b0;
            err_d   = 1'b0;
          end else begin
            // Illegal opcode: respond immediately with an all-zero result.
            state_d = ST_DONE;
            zero_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      ST_RUN: begin
        result_d[int'(cnt_q)*SLICE +: SLICE] = slice_y;
        if (cnt_q == LAST_SLICE) begin
          // zero only reflects the complete word, so it is taken as the last slice lands.
          state_d = ST_DONE;
          zero_d  = (result_d == '0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_AND;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.op_err    = err_q;
  assign bus.carryout  = 1'b0;
  assign bus.overflow  = 1'b0;

endmodule

// File: tb/tb_serial_logic_unit.sv
// tb/tb_serial_logic_unit.sv - directed self-checking bench for the serial logic unit
module tb_serial_logic_unit;
  import serial_logic_unit_pkg::*;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;
  int   n_hs;

  serial_logic_unit_if #(.WIDTH(32)) bus ();

  serial_logic_unit #(
    .WIDTH (32),
    .SLICE (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completed response handshakes.
  always @(posedge clk) begin
    if (bus.rsp_valid && bus.rsp_ready) n_hs <= n_hs + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Offer a command, then wait for rsp_valid; lat counts edges from acceptance.
  task automatic run_cmd(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input bit scramble, output int lat);
    int guard;
    guard = 0;
    while (!bus.cmd_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.a         = av;
    bus.b         = bv;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      if (scramble) begin
        bus.a      = 32'hDEAD_BEEF;
        bus.b      = 32'hDEAD_BEEF;
        bus.cmd_op = (bus.cmd_op == OP_AND) ? OP_XOR : OP_AND;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_rsp(input string tag, input int lat, input int exp_lat,
                           input logic [31:0] exp_res, input logic exp_zero, input logic exp_err);
    check({tag, "_lat"},    64'(lat),          64'(exp_lat));
    check({tag, "_result"}, 64'(bus.result),   64'(exp_res));
    check({tag, "_zero"},   64'(bus.zero),     64'(exp_zero));
    check({tag, "_err"},    64'(bus.op_err),   64'(exp_err));
    check({tag, "_flags"},  64'({bus.carryout, bus.overflow}), 64'(0));
  endtask

  // Let the handshake edge pass (rsp_ready assumed high).
  task automatic finish_rsp(input string tag);
    @(posedge clk); #1;
    check({tag, "_released"}, 64'({bus.rsp_valid, bus.cmd_ready}), 64'(2'b01));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready_valid"}, 64'({bus.cmd_ready, bus.rsp_valid}), 64'(2'b10));
    check({tag, "_result"},      64'(bus.result), 64'(0));
    check({tag, "_flags"},       64'({bus.zero, bus.op_err, bus.carryout, bus.overflow}), 64'(0));
  endtask

  initial begin
    int lat;
    int hs0;
    int stable;
    n_checks      = 0;
    n_pass        = 0;
    n_hs          = 0;
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_AND;
    bus.a         = '0;
    bus.b         = '0;
    bus.rsp_ready = 1'b1;
    #1;
    check_reset_outputs("por");
    #21 reset_n = 1'b1;

    // AND issued right after reset release; 5-edge latency.
    run_cmd(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, lat);
    check_rsp("and", lat, 5, 32'hF000_F000, 1'b0, 1'b0);
    finish_rsp("and");

    // XOR of equal operands gives zero.
    run_cmd(OP_XOR, 32'h1234_5678, 32'h1234_5678, 1'b0, lat);
    check_rsp("xor", lat, 5, 32'h0000_0000, 1'b1, 1'b0);
    finish_rsp("xor");

    // NOR with back-pressure; a command offered during DONE is ignored and
    // must not be taken on the handshake edge either.
    bus.rsp_ready = 1'b0;
    run_cmd(OP_NOR, 32'h0, 32'h0, 1'b0, lat);
    check_rsp("nor", lat, 5, 32'hFFFF_FFFF, 1'b0, 1'b0);
    hs0 = n_hs;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_AND;
    bus.a         = 32'h0;
    bus.b         = 32'h0;
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid && !bus.cmd_ready && bus.result == 32'hFFFF_FFFF && !bus.zero && !bus.op_err)
        stable++;
    end
    check("nor_hold_cycles", 64'(stable), 64'(10));
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("nor_no_same_cycle_accept", 64'({bus.rsp_valid, bus.cmd_ready}), 64'(2'b01));
    @(posedge clk); #1;
    check("nor_single_handshake", 64'(n_hs - hs0), 64'(1));
    check("nor_idle_after", 64'(bus.cmd_ready), 64'(1));

    // Illegal opcode: immediate error response.
    run_cmd(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    check_rsp("illegal", lat, 1, 32'h0, 1'b1, 1'b1);
    finish_rsp("illegal");

    // Full NAND.
    run_cmd(OP_NAND, 32'hFFFF_0000, 32'hFF00_FF00, 1'b0, lat);
    check_rsp("nand", lat, 5, 32'h00FF_FFFF, 1'b0, 1'b0);
    finish_rsp("nand");

    // NAND aborted by reset in its second RUN cycle (slice 0 already written).
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_NAND;
    bus.a         = 32'h0;
    bus.b         = 32'h0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_partial_result", 64'(bus.result), 64'(32'h0000_00FF));
    hs0 = n_hs;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge clk); #1;
    reset_n = 1'b1;
    stable = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) stable++;
    end
    check("abort_no_rsp", 64'(stable + n_hs - hs0), 64'(0));

    run_cmd(OP_OR, 32'h0000_00FF, 32'h0F00_0000, 1'b0, lat);
    check_rsp("or", lat, 5, 32'h0F00_00FF, 1'b0, 1'b0);
    finish_rsp("or");

    // Operands scrambled after acceptance must not leak into the result.
    run_cmd(OP_OR, 32'h1, 32'h2, 1'b1, lat);
    check_rsp("or_scramble", lat, 5, 32'h0000_0003, 1'b0, 1'b0);
    finish_rsp("or_scramble");

    // Legal operation with an all-zero result.
    run_cmd(OP_OR, 32'h0, 32'h0, 1'b0, lat);
    check_rsp("or_zero", lat, 5, 32'h0, 1'b1, 1'b0);
    finish_rsp("or_zero");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
